// File: rtl/axis_match_arbiter_if.sv
// AXI-Stream bundle between the feed handlers, the arbiter and the matcher.
// master: arbiter view (feed sinks, matcher source); slave: the peer side.
interface axis_match_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 2
);
    logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]        s_axis_tvalid;
    logic [NUM_SRC-1:0]        s_axis_tlast;
    logic [NUM_SRC-1:0]        s_axis_tready;
    logic [DATA_W-1:0]         m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tlast;
    logic [ID_W-1:0]           m_axis_tid;
    logic                      m_axis_tready;

    modport master (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        output m_axis_tid,
        input  m_axis_tready
    );

    modport slave (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        input  m_axis_tid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_match_arbiter.sv
// Packet-granular round-robin arbiter sharing one header matcher among feeds.
// Zero-latency pass-through of the granted source, one IDLE cycle per packet.
module axis_match_arbiter #(
    parameter int  NUM_SRC   = 4,
    parameter int  DATA_W    = 64,
    parameter int  MAX_BEATS = 16,
    localparam int ID_W      = $clog2(NUM_SRC)
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_match_arbiter_if.master bus,
    output logic                 grant_active,
    output logic [15:0]          pkt_count,
    output logic [15:0]          trunc_count
);
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic [15:0]       beat_cnt;
    logic              any_req;
    logic              at_cap;
    logic              sel_last;
    logic              accept;
    logic              pkt_end;
    logic [DATA_W-1:0] src_data [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = bus.s_axis_tdata[i*DATA_W +: DATA_W];
    end

    assign any_req  = |bus.s_axis_tvalid;
    assign at_cap   = (beat_cnt == 16'(MAX_BEATS - 1));
    assign sel_last = bus.s_axis_tlast[grant];
    assign accept   = bus.m_axis_tvalid & bus.m_axis_tready;
    assign pkt_end  = accept & bus.m_axis_tlast;

    // First requester strictly after the previous winner, wrapping.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_SRC);
            if (!found && bus.s_axis_tvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (pkt_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.s_axis_tready = '0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tdata  = src_data[grant];
        bus.m_axis_tid    = grant;
        grant_active      = 1'b0;
        unique case (state)
            XFER: begin
                bus.m_axis_tvalid        = bus.s_axis_tvalid[grant];
                bus.m_axis_tlast         = sel_last | at_cap;
                bus.s_axis_tready[grant] = bus.m_axis_tready;
                grant_active             = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A cut packet leaves the source's tail to compete as a fresh packet.
    always_ff @(posedge aclk) begin
        if (areset) begin
            grant       <= '0;
            last_grant  <= ID_W'(NUM_SRC - 1);
            beat_cnt    <= '0;
            pkt_count   <= '0;
            trunc_count <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant    <= pick;
                beat_cnt <= '0;
            end
            if (state == XFER && accept) begin
                beat_cnt <= beat_cnt + 16'd1;
                if (bus.m_axis_tlast) begin
                    last_grant <= grant;
                    pkt_count  <= pkt_count + 16'd1;
                    if (!sel_last) begin
                        trunc_count <= trunc_count + 16'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_match_arbiter.sv
// Directed bench for axis_match_arbiter with a queue-fed source model and
// a cycle-level reference model of the arbitration rules.
module tb_axis_match_arbiter;
    localparam int NS = 4;
    localparam int DW = 64;
    localparam int MB = 16;
    localparam int IW = 2;

    logic        aclk = 1'b0;
    logic        areset;
    logic        grant_active;
    logic [15:0] pkt_count;
    logic [15:0] trunc_count;

    always #5 aclk = ~aclk;

    axis_match_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .ID_W(IW)) bus ();

    axis_match_arbiter #(
        .NUM_SRC  (NS),
        .DATA_W   (DW),
        .MAX_BEATS(MB)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .bus         (bus.master),
        .grant_active(grant_active),
        .pkt_count   (pkt_count),
        .trunc_count (trunc_count)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          src;
        logic [63:0] data;
        logic        last;
        int          cyc;
    } obeat_t;

    beat_t       srcq [NS][$];
    logic [DW-1:0] s_data [NS];
    logic [NS-1:0] s_valid;
    logic [NS-1:0] s_last;
    logic [NS-1:0] acc_mask;
    logic          m_ready;
    logic          bp_mode;

    for (genvar i = 0; i < NS; i++) begin : g_pack
        assign bus.s_axis_tdata[i*DW +: DW] = s_data[i];
    end
    assign bus.s_axis_tvalid = s_valid;
    assign bus.s_axis_tlast  = s_last;
    assign bus.m_axis_tready = m_ready;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Sources: present the queue head, retire it after a handshake.
    always @(posedge aclk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc_mask[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
                s_valid[i] = 1'b1;
                s_data[i]  = srcq[i][0].data;
                s_last[i]  = srcq[i][0].last;
            end else begin
                s_valid[i] = 1'b0;
                s_data[i]  = '0;
                s_last[i]  = 1'b0;
            end
        end
        if (bp_mode) m_ready = ~m_ready;
    end

    // Reference model: owner -1 means no grant held.
    int     owner = -1;
    int     prev  = NS - 1;
    int     mbeats = 0;
    int     mtid  = 0;
    int     mpkt  = 0;
    int     mtrunc = 0;
    bit     live  = 1'b0;
    int     cyc   = 0;
    int     xfer_cycles = 0;
    obeat_t olog [$];
    int     glog [$];
    int     gcyc [$];

    always @(negedge aclk) begin
        logic [NS-1:0] e_ready;
        logic          e_valid;
        logic          e_last;
        obeat_t        ob;
        cyc++;
        acc_mask = bus.s_axis_tready & bus.s_axis_tvalid;
        if (live) begin
            e_ready = '0;
            e_valid = 1'b0;
            e_last  = 1'b0;
            if (owner >= 0) begin
                e_valid        = s_valid[owner];
                e_last         = s_last[owner] || (mbeats == MB - 1);
                e_ready[owner] = m_ready;
                xfer_cycles++;
            end
            check("s_tready", 64'(bus.s_axis_tready), 64'(e_ready));
            check("m_tvalid", 64'(bus.m_axis_tvalid), 64'(e_valid));
            check_i("m_tid", int'(bus.m_axis_tid), mtid);
            check_i("grant_active", int'(grant_active), int'(owner >= 0));
            check_i("pkt_count", int'(pkt_count), mpkt);
            check_i("trunc_count", int'(trunc_count), mtrunc);
            if (e_valid) begin
                check("m_tdata", bus.m_axis_tdata, s_data[owner]);
                check("m_tlast", 64'(bus.m_axis_tlast), 64'(e_last));
            end
            if (!areset) begin
                if (owner < 0) begin
                    for (int k = 1; k <= NS; k++) begin
                        if (owner < 0 && s_valid[(prev + k) % NS]) begin
                            owner  = (prev + k) % NS;
                            mtid   = owner;
                            mbeats = 0;
                            glog.push_back(owner);
                            gcyc.push_back(cyc);
                        end
                    end
                end else if (e_valid && m_ready) begin
                    ob.src  = owner;
                    ob.data = s_data[owner];
                    ob.last = e_last;
                    ob.cyc  = cyc;
                    olog.push_back(ob);
                    mbeats++;
                    if (e_last) begin
                        prev = owner;
                        mpkt = (mpkt + 1) % 65536;
                        if (!s_last[owner]) mtrunc = (mtrunc + 1) % 65536;
                        owner = -1;
                    end
                end
            end
        end
        if (areset) begin
            owner  = -1;
            prev   = NS - 1;
            mbeats = 0;
            mtid   = 0;
            mpkt   = 0;
            mtrunc = 0;
            live   = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic push(input int s, input int n, input logic [63:0] base,
                        input bit last_at_end);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + 64'(k);
            b.last = last_at_end && (k == n - 1);
            srcq[s].push_back(b);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) srcq[i].delete();
    endtask

    task automatic clear_logs();
        olog.delete();
        glog.delete();
        gcyc.delete();
    endtask

    task automatic do_reset();
        areset  = 1'b1;
        bp_mode = 1'b0;
        m_ready = 1'b1;
        clear_all();
        step(2);
        areset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_beats(input int n, input int lim);
        int c = 0;
        while (olog.size() < n && c < lim) begin
            step(1);
            c++;
        end
        check_i("beat_wait", olog.size() >= n ? 1 : 0, 1);
    endtask

    initial begin
        areset   = 1'b1;
        m_ready  = 1'b1;
        bp_mode  = 1'b0;
        acc_mask = '0;
        s_valid  = '0;
        s_last   = '0;
        for (int i = 0; i < NS; i++) s_data[i] = '0;

        do_reset();
        check("rst_s_tready", 64'(bus.s_axis_tready), 64'h0);
        check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'h0);
        check("rst_m_tlast", 64'(bus.m_axis_tlast), 64'h0);
        check("rst_m_tid", 64'(bus.m_axis_tid), 64'h0);
        check("rst_active", 64'(grant_active), 64'h0);
        check("rst_pkt", 64'(pkt_count), 64'h0);
        check("rst_trunc", 64'(trunc_count), 64'h0);

        // Single source, three beats.
        push(2, 3, 64'hA0, 1'b1);
        wait_beats(3, 20);
        step(1);
        if (olog.size() >= 3 && gcyc.size() >= 1) begin
            for (int k = 0; k < 3; k++) begin
                check_i("single_tid", olog[k].src, 2);
                check("single_data", olog[k].data, 64'hA0 + 64'(k));
                check_i("single_last", int'(olog[k].last), int'(k == 2));
            end
            check_i("single_latency", olog[0].cyc, gcyc[0] + 1);
            check_i("single_consec", olog[2].cyc, olog[0].cyc + 2);
        end
        check("single_pkt", 64'(pkt_count), 64'd1);

        // Round-robin with every source saturated.
        areset = 1'b1;
        clear_all();
        for (int s = 0; s < NS; s++) begin
            for (int p = 0; p < 6; p++) push(s, 2, 64'(s * 256 + p * 16), 1'b1);
        end
        step(2);
        areset = 1'b0;
        clear_logs();
        step(40);
        check("rr_pkt_40", 64'(pkt_count), 64'd13);
        check("rr_trunc", 64'(trunc_count), 64'd0);
        if (glog.size() >= 8) begin
            for (int k = 0; k < 8; k++) check_i("rr_order", glog[k], k % NS);
        end else begin
            check_i("rr_grants", glog.size(), 8);
        end

        // Truncation at MAX_BEATS while source 0 waits.
        do_reset();
        push(1, 20, 64'h1100, 1'b1);
        for (int c = 0; c < 10 && !grant_active; c++) step(1);
        push(0, 2, 64'h0500, 1'b1);
        wait_beats(22, 100);
        if (olog.size() >= 22) begin
            check_i("trunc_b15_src", olog[15].src, 1);
            check_i("trunc_b15_last", int'(olog[15].last), 1);
            check_i("trunc_b14_last", int'(olog[14].last), 0);
            check_i("trunc_next_src", olog[16].src, 0);
            check_i("trunc_s0_last", int'(olog[17].last), 1);
            check_i("trunc_tail_src", olog[18].src, 1);
            check("trunc_tail_data", olog[18].data, 64'h1110);
            check("trunc_end_data", olog[21].data, 64'h1113);
            check_i("trunc_end_last", int'(olog[21].last), 1);
        end
        check("trunc_count", 64'(trunc_count), 64'd1);
        check("trunc_pkt", 64'(pkt_count), 64'd3);

        // Backpressure: ready alternates, starting high on the grant cycle.
        do_reset();
        m_ready = 1'b0;
        bp_mode = 1'b1;
        push(3, 4, 64'h3300, 1'b1);
        xfer_cycles = 0;
        wait_beats(4, 40);
        step(1);
        bp_mode = 1'b0;
        m_ready = 1'b1;
        check_i("bp_xfer_cycles", xfer_cycles, 8);
        if (olog.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("bp_data", olog[k].data, 64'h3300 + 64'(k));
            end
        end
        check_i("bp_beats", olog.size(), 4);
        check("bp_pkt", 64'(pkt_count), 64'd1);

        // Reset during beat 2 of a 5-beat packet.
        clear_logs();
        push(0, 5, 64'h0A00, 1'b1);
        wait_beats(1, 20);
        areset = 1'b1;
        srcq[0].delete();
        step(1);
        areset = 1'b0;
        check("mid_s_tready", 64'(bus.s_axis_tready), 64'h0);
        check("mid_m_tvalid", 64'(bus.m_axis_tvalid), 64'h0);
        check("mid_m_tlast", 64'(bus.m_axis_tlast), 64'h0);
        check("mid_m_tid", 64'(bus.m_axis_tid), 64'h0);
        check("mid_active", 64'(grant_active), 64'h0);
        check("mid_pkt", 64'(pkt_count), 64'h0);
        check("mid_trunc", 64'(trunc_count), 64'h0);
        clear_logs();
        push(1, 2, 64'h0B00, 1'b1);
        wait_beats(2, 20);
        step(1);
        if (glog.size() >= 1) check_i("mid_regrant", glog[0], 1);
        check("mid_pkt_after", 64'(pkt_count), 64'd1);

        // tlast coinciding with the cap, then a single-beat packet.
        do_reset();
        push(2, 16, 64'h2200, 1'b1);
        push(2, 1, 64'h22FF, 1'b1);
        wait_beats(17, 60);
        step(2);
        check("cap_pkt", 64'(pkt_count), 64'd2);
        check("cap_trunc", 64'(trunc_count), 64'd0);
        check("cap_idle", 64'(grant_active), 64'd0);
        if (olog.size() >= 17) begin
            check_i("single_beat_last", int'(olog[16].last), 1);
            check_i("single_beat_gap", olog[16].cyc, olog[15].cyc + 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
